seg7_scan_driver: RTL and testbench

//  Multiplexed driver for the 4-digit common-anode seven-segment display on the board.

---
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode seven-segment scanner with a frame-synchronous load path.
// Loaded values go through a pending register and reach the display only at a frame wrap.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 2,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic          slot_end, frame_end;

  logic [15:0]   pend_value_reg, act_value_reg;
  logic [3:0]    pend_dp_reg, act_dp_reg;
  logic [3:0]    pend_blank_reg, act_blank_reg;
  logic          pend_valid_reg;

  logic [3:0]    an_reg, an_next;
  logic [7:0]    seg_reg, seg_next;
  logic          frame_done_reg;

  logic [3:0]    upper_zero;
  logic [3:0]    nib;
  logic          dark;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // upper_zero[k]: every active nibble from digit k upward is zero
  for (genvar gi = 0; gi < 4; gi++) begin : g_upper_zero
    assign upper_zero[gi] = (act_value_reg[15:4*gi] == '0);
  end

  always_comb begin
    slot_end  = (cnt_reg == CNT_LAST);
    frame_end = slot_end && (idx_reg == 2'd3);
    cnt_next  = slot_end ? '0 : cnt_reg + CW'(1);
    idx_next  = slot_end ? idx_reg + 2'd1 : idx_reg;
  end

  always_comb begin
    nib      = act_value_reg[{idx_reg, 2'b00} +: 4];
    dark     = act_blank_reg[idx_reg] ||
               (LZ_BLANK && (idx_reg != 2'd0) && upper_zero[idx_reg]);
    an_next  = 4'hF;
    seg_next = 8'hFF;
    if (cnt_reg >= GUARD_C) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = dark ? 8'hFF : {~act_dp_reg[idx_reg], hex7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      idx_reg        <= 2'd0;
      pend_value_reg <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '0;
      pend_valid_reg <= 1'b0;
      act_value_reg  <= '0;
      act_dp_reg     <= '0;
      act_blank_reg  <= '0;
      an_reg         <= 4'hF;
      seg_reg        <= 8'hFF;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      // registered so the pulse lines up with the last cycle of digit 3
      frame_done_reg <= (cnt_reg == CNT_PRE) && (idx_reg == 2'd3);

      if (frame_end && pend_valid_reg) begin
        act_value_reg <= pend_value_reg;
        act_dp_reg    <= pend_dp_reg;
        act_blank_reg <= pend_blank_reg;
      end

      // a load on the commit edge stays pending for the following frame
      if (load) begin
        pend_value_reg <= value;
        pend_dp_reg    <= dp;
        pend_blank_reg <= blank;
        pend_valid_reg <= 1'b1;
      end else if (frame_end) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected per-slot an/seg pushed with each load,
// popped while capturing whole scan frames from the plain and leading-zero-blanking instances.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  an, an_lz;
  logic [7:0]  seg, seg_lz;
  logic        frame_done, frame_done_lz;

  int tests_run = 0;
  int tests_failed = 0;
  int frame_no = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  typedef struct {
    int         at;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } ld_t;

  exp_t exp_q[$];
  ld_t  ld_q[$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(8), .GUARD(2), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  seg7_scan_driver #(.SCAN_DIV(8), .GUARD(2), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .an(an_lz), .seg(seg_lz), .frame_done(frame_done_lz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected display of one frame for the given active data
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] bl, input bit lz);
    for (int k = 0; k < 4; k++) begin
      exp_t        e;
      logic [3:0]  n;
      bit          drk;
      n     = 4'((v >> (4 * k)) & 16'hF);
      drk   = bl[k] || (lz && k > 0 && ((v >> (4 * k)) == 16'h0));
      e.an  = ~(4'b0001 << k);
      e.seg = drk ? 8'hFF : {~d[k], hex_tab[n]};
      exp_q.push_back(e);
    end
  endtask

  // Captures 32 consecutive output cycles (one frame, slot 0 first) and drives queued loads.
  task automatic capture_frame(input bit lz);
    int fd_bad;
    int multi_an;
    fd_bad   = 0;
    multi_an = 0;
    for (int k = 0; k < 4; k++) begin
      int         guards;
      bit         got_lit;
      bit         steady;
      logic [3:0] lit_an;
      logic [7:0] lit_seg;
      exp_t       e;
      guards  = 0;
      got_lit = 1'b0;
      steady  = 1'b1;
      lit_an  = 4'hF;
      lit_seg = 8'hFF;
      for (int c = 0; c < 8; c++) begin
        int         fc;
        logic [3:0] a_s;
        logic [7:0] s_s;
        logic       fd_s;
        fc = k * 8 + c;
        @(negedge clk);
        a_s  = lz ? an_lz : an;
        s_s  = lz ? seg_lz : seg;
        fd_s = lz ? frame_done_lz : frame_done;
        load = 1'b0;
        if (a_s == 4'hF && s_s == 8'hFF) guards++;
        else if (!got_lit) begin
          got_lit = 1'b1;
          lit_an  = a_s;
          lit_seg = s_s;
        end else if (a_s !== lit_an || s_s !== lit_seg) steady = 1'b0;
        if ($countones(~a_s) > 1) multi_an++;
        if (fd_s !== (fc == 30)) fd_bad++;
        if (ld_q.size() > 0 && ld_q[0].at == fc) begin
          ld_t l;
          l     = ld_q.pop_front();
          value = l.v;
          dp    = l.dp;
          blank = l.bl;
          load  = 1'b1;
        end
      end
      $display("[TB] frame %0d slot %0d an=%h seg=%h guards=%0d", frame_no, k, lit_an, lit_seg, guards);
      check("guard cycles", guards, 2);
      check("slot steady", steady, 1);
      if (exp_q.size() == 0) begin
        check("scoreboard empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("f%0d s%0d an", frame_no, k), lit_an, e.an);
        check($sformatf("f%0d s%0d seg", frame_no, k), lit_seg, e.seg);
      end
    end
    check("frame_done timing", fd_bad, 0);
    check("single anode", multi_an, 0);
    frame_no++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1 reset
    repeat (3) @(negedge clk);
    check("rst an", an, 4'hF);
    check("rst seg", seg, 8'hFF);
    check("rst frame_done", frame_done, 1'b0);
    check("rst an lz", an_lz, 4'hF);
    rst = 1'b0;

    // F0: cleared display; T2 load queued for F1
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
    ld_q.push_back('{5, 16'h12AF, 4'b0001, 4'b0000});
    capture_frame(1'b0);

    // F1: 12AF; T3 two loads in one frame, last wins
    push_frame(16'h12AF, 4'b0001, 4'b0000, 1'b0);
    ld_q.push_back('{3, 16'h1111, 4'b0000, 4'b0000});
    ld_q.push_back('{10, 16'h2222, 4'b0000, 4'b0000});
    capture_frame(1'b0);

    // F2: 2222; pending 4444, then a load on the frame_done cycle
    push_frame(16'h2222, 4'b0000, 4'b0000, 1'b0);
    ld_q.push_back('{12, 16'h4444, 4'b0000, 4'b0000});
    ld_q.push_back('{30, 16'h8888, 4'b0000, 4'b0100});
    capture_frame(1'b0);

    // F3: old pending committed, commit-cycle load held back a frame
    push_frame(16'h4444, 4'b0000, 4'b0000, 1'b0);
    capture_frame(1'b0);

    // F4: T4 forced blank on digit 2
    push_frame(16'h8888, 4'b0000, 4'b0100, 1'b0);
    ld_q.push_back('{4, 16'h0050, 4'b0000, 4'b0000});
    capture_frame(1'b0);

    // F5/F6: T5 leading-zero blanking instance
    push_frame(16'h0050, 4'b0000, 4'b0000, 1'b1);
    ld_q.push_back('{7, 16'h0000, 4'b0000, 4'b0000});
    capture_frame(1'b1);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);
    capture_frame(1'b1);

    // T6: load then reset in slot 2 at cnt=4; the pending load must be lost
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c == 5) begin
        value = 16'h9999;
        dp    = 4'b1111;
        blank = 4'b0000;
        load  = 1'b1;
      end
    end
    check("mid-slot an", an, 4'hB);
    check("mid-slot seg", seg, 8'hC0);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst an", an, 4'hF);
    check("mid rst seg", seg, 8'hFF);
    check("mid rst frame_done", frame_done, 1'b0);
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
    capture_frame(1'b0);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
    capture_frame(1'b0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
